// File: rtl/fc_err_receiver.sv
// rtl/fc_err_receiver.sv - FC error-propagation receiver with per-cell batch accumulation and averaged drain
//
// Captures one sample's FRT_CELL error words from the FC block, adds them into
// per-cell saturating accumulators once the sample is confirmed complete, and on
// batch end streams the batch-averaged (divide by BATCH_SIZE) errors downstream.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_bck_prop_start        level, FC back-propagation of one sample in progress
//   i_fc_err_prop/addr      error word and its cell index from the FC block
//   i_fc_bck_prop_end       level, FC block finished the current sample
//   i_batch_end             one-cycle pulse, batch complete, drain requested
//   o_conv_err_valid/ready  drain handshake
//   o_conv_err_data/addr    averaged saturated error word and its cell index
//   o_conv_err_last         marks word FRT_CELL-1
//   o_rx_err                one-cycle pulse, sample discarded
//   o_sample_cnt            samples accumulated in the current batch
module fc_err_receiver #(
  parameter int FRT_CELL   = 32,
  parameter int BATCH_SIZE = 32,
  parameter int ACC_W      = 22
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_bck_prop_start,
  input  logic [15:0] i_fc_err_prop,
  input  logic [15:0] i_fc_err_addr,
  input  logic        i_fc_bck_prop_end,
  input  logic        i_batch_end,
  output logic        o_conv_err_valid,
  input  logic        i_conv_err_ready,
  output logic [15:0] o_conv_err_data,
  output logic [15:0] o_conv_err_addr,
  output logic        o_conv_err_last,
  output logic        o_rx_err,
  output logic [15:0] o_sample_cnt
);

  localparam int SHIFT = $clog2(BATCH_SIZE);
  localparam int IDX_W = (FRT_CELL > 1) ? $clog2(FRT_CELL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRT_CELL - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_WAIT_END, S_ACCUM, S_HOLD, S_DRAIN
  } state_t;

  state_t                  r_state;
  logic [15:0]             r_stage [FRT_CELL];
  logic signed [ACC_W-1:0] r_acc   [FRT_CELL];
  logic [IDX_W-1:0]        r_exp_idx;
  logic [IDX_W-1:0]        r_idx;
  logic [15:0]             r_addr_q;
  logic                    r_batch_pend;

  logic [15:0]             w_exp16;
  logic                    w_capture;
  logic                    w_cap_last;
  logic [ACC_W:0]          w_sum;
  logic signed [ACC_W-1:0] w_acc_sat;
  logic                    w_hs;
  logic [IDX_W-1:0]        w_next_idx;

  // Average of one accumulator: arithmetic shift, then clamp to 16-bit signed.
  function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] t;
    t = a >>> SHIFT;
    if ((&t[ACC_W-1:15]) || !(|t[ACC_W-1:15]))
      return t[15:0];
    else if (t[ACC_W-1])
      return 16'h8000;
    else
      return 16'h7FFF;
  endfunction

  // A word is taken only when the address is the expected one AND the address
  // actually moved into it on this cycle; an address left over from a previous
  // run therefore never counts as the start of a new stream.
  assign w_exp16    = 16'(r_exp_idx);
  assign w_capture  = (i_fc_err_addr == w_exp16) &&
                      ((r_exp_idx == '0) ? (r_addr_q != 16'd0)
                                         : (r_addr_q == w_exp16 - 16'd1));
  assign w_cap_last = w_capture && (r_exp_idx == LAST_IDX);

  // One extra bit of headroom so overflow is visible before clamping.
  assign w_sum = {r_acc[r_idx][ACC_W-1], r_acc[r_idx]} +
                 {{(ACC_W-15){r_stage[r_idx][15]}}, r_stage[r_idx]};

  always_comb begin
    w_acc_sat = w_sum[ACC_W-1:0];
    if (w_sum[ACC_W] != w_sum[ACC_W-1])
      w_acc_sat = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
  end

  assign w_hs       = o_conv_err_valid && i_conv_err_ready;
  assign w_next_idx = r_idx + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state          <= S_IDLE;
      r_exp_idx        <= '0;
      r_idx            <= '0;
      r_addr_q         <= 16'd0;
      r_batch_pend     <= 1'b0;
      o_conv_err_valid <= 1'b0;
      o_conv_err_data  <= 16'd0;
      o_conv_err_addr  <= 16'd0;
      o_conv_err_last  <= 1'b0;
      o_rx_err         <= 1'b0;
      o_sample_cnt     <= 16'd0;
      for (int i = 0; i < FRT_CELL; i++) begin
        r_stage[i] <= 16'd0;
        r_acc[i]   <= '0;
      end
    end else begin
      r_addr_q <= i_fc_err_addr;
      o_rx_err <= 1'b0;

      // A drain request that cannot start now is remembered until IDLE.
      if (i_batch_end && (r_state != S_IDLE))
        r_batch_pend <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (i_bck_prop_start) begin
            r_state   <= S_CAPTURE;
            r_exp_idx <= '0;
            if (i_batch_end)
              r_batch_pend <= 1'b1;
          end else if (i_batch_end || r_batch_pend) begin
            r_state          <= S_DRAIN;
            r_batch_pend     <= 1'b0;
            r_idx            <= '0;
            o_conv_err_valid <= 1'b1;
            o_conv_err_data  <= sat16(r_acc[0]);
            o_conv_err_addr  <= 16'd0;
            o_conv_err_last  <= (FRT_CELL == 1);
          end
        end

        S_CAPTURE: begin
          if (w_capture) begin
            r_stage[r_exp_idx] <= i_fc_err_prop;
            r_exp_idx          <= r_exp_idx + 1'b1;
          end
          if (w_cap_last) begin
            r_idx   <= '0;
            r_state <= i_fc_bck_prop_end ? S_ACCUM : S_WAIT_END;
          end else if (i_fc_bck_prop_end) begin
            o_rx_err <= 1'b1;
            r_state  <= S_HOLD;
          end else if (!i_bck_prop_start) begin
            o_rx_err <= 1'b1;
            r_state  <= S_IDLE;
          end
        end

        S_WAIT_END: begin
          if (i_fc_bck_prop_end) begin
            r_idx   <= '0;
            r_state <= S_ACCUM;
          end else if (!i_bck_prop_start) begin
            o_rx_err <= 1'b1;
            r_state  <= S_IDLE;
          end
        end

        S_ACCUM: begin
          r_acc[r_idx] <= w_acc_sat;
          r_idx        <= w_next_idx;
          if (r_idx == LAST_IDX) begin
            r_idx   <= '0;
            r_state <= S_HOLD;
            if (o_sample_cnt != 16'hFFFF)
              o_sample_cnt <= o_sample_cnt + 16'd1;
          end
        end

        S_HOLD: begin
          if (!i_bck_prop_start)
            r_state <= S_IDLE;
        end

        S_DRAIN: begin
          if (w_hs) begin
            if (r_idx == LAST_IDX) begin
              r_state          <= S_IDLE;
              r_idx            <= '0;
              o_conv_err_valid <= 1'b0;
              o_conv_err_data  <= 16'd0;
              o_conv_err_addr  <= 16'd0;
              o_conv_err_last  <= 1'b0;
              o_sample_cnt     <= 16'd0;
              for (int i = 0; i < FRT_CELL; i++)
                r_acc[i] <= '0;
            end else begin
              r_idx           <= w_next_idx;
              o_conv_err_data <= sat16(r_acc[w_next_idx]);
              o_conv_err_addr <= 16'(w_next_idx);
              o_conv_err_last <= (w_next_idx == LAST_IDX);
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_err_receiver.sv
// tb/tb_fc_err_receiver.sv - self-checking bench for fc_err_receiver
module tb_fc_err_receiver;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        bck_prop_start;
  logic [15:0] fc_err_prop;
  logic [15:0] fc_err_addr;
  logic        fc_bck_prop_end;
  logic        batch_end;
  logic        conv_err_valid;
  logic        conv_err_ready;
  logic [15:0] conv_err_data;
  logic [15:0] conv_err_addr;
  logic        conv_err_last;
  logic        rx_err;
  logic [15:0] sample_cnt;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          acc_m [N];
  int          cnt_m;
  logic [15:0] cur_w [N];
  logic [15:0] exp_w [N];

  always #5 clk = ~clk;

  fc_err_receiver #(.FRT_CELL(32), .BATCH_SIZE(32), .ACC_W(22)) dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_bck_prop_start  (bck_prop_start),
    .i_fc_err_prop     (fc_err_prop),
    .i_fc_err_addr     (fc_err_addr),
    .i_fc_bck_prop_end (fc_bck_prop_end),
    .i_batch_end       (batch_end),
    .o_conv_err_valid  (conv_err_valid),
    .i_conv_err_ready  (conv_err_ready),
    .o_conv_err_data   (conv_err_data),
    .o_conv_err_addr   (conv_err_addr),
    .o_conv_err_last   (conv_err_last),
    .o_rx_err          (rx_err),
    .o_sample_cnt      (sample_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Reference: a confirmed sample adds into each cell with 22-bit signed clamping.
  task automatic model_accept();
    for (int i = 0; i < N; i++)
      acc_m[i] = clampi(acc_m[i] + int'($signed(cur_w[i])), -(1 << 21), (1 << 21) - 1);
    if (cnt_m < 65535) cnt_m++;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) acc_m[i] = 0;
    cnt_m = 0;
  endtask

  task automatic run_sample(input int abort_at, input bit end_with_last,
                            input int collide_at, input logic [15:0] stale);
    bck_prop_start = 1'b1;
    fc_err_addr    = stale;
    tick();
    tick();
    for (int i = 0; i < N; i++) begin
      if (i == abort_at) begin
        fc_bck_prop_end = 1'b1;
        tick();
        chk("abort_rx_err_pulse", 32'(rx_err), 32'd1);
        fc_bck_prop_end = 1'b0;
        bck_prop_start  = 1'b0;
        tick();
        chk("abort_rx_err_single", 32'(rx_err), 32'd0);
        chk("abort_cnt_unchanged", 32'(sample_cnt), 32'(cnt_m));
        tick();
        return;
      end
      fc_err_addr     = 16'(i);
      fc_err_prop     = cur_w[i];
      batch_end       = (i == collide_at);
      fc_bck_prop_end = end_with_last && (i == N - 1);
      tick();
      batch_end = 1'b0;
    end
    if (!end_with_last) begin
      fc_bck_prop_end = 1'b1;
      tick();
    end
    fc_bck_prop_end = 1'b0;
    bck_prop_start  = 1'b0;
    repeat (N - 1) tick();
    chk("cnt_before_accum_end", 32'(sample_cnt), 32'(cnt_m));
    chk("no_rx_err", 32'(rx_err), 32'd0);
    tick();
    model_accept();
    chk("cnt_after_accum", 32'(sample_cnt), 32'(cnt_m));
    tick();
  endtask

  // mode 0: ready high, 1: ready 1,0,0 repeating, 2: random ready
  task automatic run_drain(input bit pulse, input int mode, input int reset_after);
    int hs;
    int cyc;
    bit rdy;
    for (int i = 0; i < N; i++)
      exp_w[i] = 16'(clampi(acc_m[i] >>> 5, -32768, 32767));
    if (pulse) begin
      batch_end = 1'b1;
      tick();
      batch_end = 1'b0;
    end else begin
      tick();
    end
    hs  = 0;
    cyc = 0;
    while (hs < N && cyc < 400) begin
      if (hs == reset_after) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_mid_drain_valid", 32'(conv_err_valid), 32'd0);
        chk("reset_mid_drain_cnt", 32'(sample_cnt), 32'd0);
        model_clear();
        conv_err_ready = 1'b0;
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      conv_err_ready = rdy;
      chk($sformatf("drain_valid[%0d]", hs), 32'(conv_err_valid), 32'd1);
      chk($sformatf("drain_addr[%0d]", hs), 32'(conv_err_addr), 32'(hs));
      chk($sformatf("drain_data[%0d]", hs), 32'(conv_err_data), 32'(exp_w[hs]));
      chk($sformatf("drain_last[%0d]", hs), 32'(conv_err_last), 32'(hs == N - 1));
      tick();
      cyc++;
      if (rdy) hs++;
    end
    conv_err_ready = 1'b0;
    chk("drain_handshakes", 32'(hs), 32'(N));
    chk("drain_done_valid", 32'(conv_err_valid), 32'd0);
    chk("drain_done_cnt", 32'(sample_cnt), 32'd0);
    model_clear();
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) cur_w[i] = 16'($urandom);
  endtask

  initial begin
    reset           = 1'b1;
    bck_prop_start  = 1'b0;
    fc_err_prop     = 16'd0;
    fc_err_addr     = 16'd0;
    fc_bck_prop_end = 1'b0;
    batch_end       = 1'b0;
    conv_err_ready  = 1'b0;
    model_clear();
    repeat (3) tick();
    chk("rst_valid", 32'(conv_err_valid), 32'd0);
    chk("rst_data", 32'(conv_err_data), 32'd0);
    chk("rst_addr", 32'(conv_err_addr), 32'd0);
    chk("rst_last", 32'(conv_err_last), 32'd0);
    chk("rst_rx_err", 32'(rx_err), 32'd0);
    chk("rst_cnt", 32'(sample_cnt), 32'd0);
    reset = 1'b0;
    tick();

    // single sample, ramp i*4, averaged over the full batch size
    for (int i = 0; i < N; i++) cur_w[i] = 16'(i * 4);
    run_sample(-1, 1'b0, -1, 16'd31);
    chk("single_word8", 32'(clampi(acc_m[8] >>> 5, -32768, 32767)), 32'd1);
    run_drain(1'b1, 0, -1);

    // full batch of a constant word
    for (int i = 0; i < N; i++) cur_w[i] = 16'h0100;
    for (int s = 0; s < 32; s++)
      run_sample(-1, 1'($urandom_range(0, 1)), -1, 16'($urandom_range(1, 31)));
    run_drain(1'b1, 0, -1);

    // saturation of the accumulators and of the averaged output
    for (int i = 0; i < N; i++) cur_w[i] = 16'h7FFF;
    for (int s = 0; s < 66; s++)
      run_sample(-1, 1'($urandom_range(0, 1)), -1, 16'd31);
    run_drain(1'b1, 2, -1);

    // aborted sample followed by a good one, stalled drain
    fill_random();
    run_sample(16, 1'b0, -1, 16'd31);
    fill_random();
    run_sample(-1, 1'b0, -1, 16'd31);
    run_drain(1'b1, 1, -1);

    // batch_end during capture is deferred until the sample is accumulated
    for (int s = 0; s < 3; s++) begin
      fill_random();
      run_sample(-1, 1'($urandom_range(0, 1)), (s == 2) ? 10 : -1, 16'($urandom_range(1, 31)));
    end
    chk("collision_no_early_drain", 32'(conv_err_valid), 32'd0);
    run_drain(1'b0, 1, -1);

    // reset mid-drain discards everything
    fill_random();
    run_sample(-1, 1'b0, -1, 16'd31);
    run_drain(1'b1, 0, 5);
    tick();
    fill_random();
    run_sample(-1, 1'b1, -1, 16'd7);
    run_drain(1'b1, 2, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
